// File: rtl/xp_issue_sched.sv
// Round-robin issue scheduler feeding a shared fixed-latency datapath; responses routed back by tag.
// Define XP_ISSUE_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module xp_issue_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned LATENCY = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*DW-1:0] req_op1_i,
  input  logic [NUM_REQ*DW-1:0] req_op2_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic                  flush_i,
  output logic                  dp_valid_o,
  output logic [DW-1:0]         dp_op1_o,
  output logic [DW-1:0]         dp_op2_o,
  input  logic [DW-1:0]         dp_res_i,
  input  logic [DW-1:0]         dp_res2_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]         rsp_res_o,
  output logic [DW-1:0]         rsp_res2_o,
  output logic                  busy_o,
  output logic                  drain_done_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                   state_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [LATENCY:0]         tag_vld_q;
  logic [LATENCY:0][IW-1:0] tag_id_q;
  logic                     dp_valid_q;
  logic [DW-1:0]            dp_op1_q, dp_op2_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic [DW-1:0]            rsp_res_q, rsp_res2_q;
  logic                     busy_q, drain_done_q;

  logic [NUM_REQ-1:0]       grant_c;
  logic [IW-1:0]            gnt_idx_c;
  logic                     gnt_any_c;
  logic                     issue_en_c;
  logic                     xfer_c;
  logic [DW-1:0]            op1_arr [NUM_REQ];
  logic [DW-1:0]            op2_arr [NUM_REQ];

  assign issue_en_c = (state_q != ST_DRAIN) && !flush_i;

`ifdef XP_ISSUE_FIXED_PRIO_EN
  // Lowest-index valid requester wins; scanning downward leaves the lowest as final winner.
  always_comb begin
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        gnt_idx_c = IW'(k);
        gnt_any_c = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand_c;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    cand_c    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = IW'((32'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any_c && req_valid_i[cand_c]) begin
        gnt_idx_c = cand_c;
        gnt_any_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (xfer_c) begin
      ptr_q <= (gnt_idx_c == IW'(NUM_REQ - 1)) ? '0 : IW'(gnt_idx_c + IW'(1));
    end
  end
`endif

  always_comb begin
    grant_c = '0;
    if (gnt_any_c && issue_en_c) grant_c[gnt_idx_c] = 1'b1;
  end

  assign req_ready_o = grant_c;
  assign xfer_c      = |grant_c;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op1_arr[i] = req_op1_i[i*DW +: DW];
      op2_arr[i] = req_op2_i[i*DW +: DW];
    end
  end

  // A response leaves the in-flight count when its result is sampled.
  assign cnt_d = cnt_q + CW'(xfer_c) - CW'(tag_vld_q[LATENCY]);

  // Launch register and requester-tag pipeline aligned with the datapath latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dp_valid_q <= 1'b0;
      dp_op1_q   <= '0;
      dp_op2_q   <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      cnt_q      <= '0;
    end else begin
      dp_valid_q <= xfer_c;
      if (xfer_c) begin
        dp_op1_q <= op1_arr[gnt_idx_c];
        dp_op2_q <= op2_arr[gnt_idx_c];
      end
      tag_vld_q <= {tag_vld_q[LATENCY-1:0], xfer_c};
      tag_id_q  <= {tag_id_q[LATENCY-1:0], gnt_idx_c};
      cnt_q     <= cnt_d;
    end
  end

  // Result capture and one-hot return; busy covers the response cycle itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_res2_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (tag_vld_q[LATENCY]) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_id_q[LATENCY];
        rsp_res_q   <= dp_res_i;
        rsp_res2_q  <= dp_res2_i;
      end
      busy_q <= (cnt_d != '0) || tag_vld_q[LATENCY];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_i)     state_q <= ST_DRAIN;
          else if (xfer_c) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (flush_i)                         state_q <= ST_DRAIN;
          else if (cnt_d == '0 && !xfer_c)     state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (cnt_d == '0) begin
            state_q      <= ST_IDLE;
            drain_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dp_valid_o   = dp_valid_q;
  assign dp_op1_o     = dp_op1_q;
  assign dp_op2_o     = dp_op2_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_res_o    = rsp_res_q;
  assign rsp_res2_o   = rsp_res2_q;
  assign busy_o       = busy_q;
  assign drain_done_o = drain_done_q;

endmodule

// File: tb/tb_xp_issue_sched.sv
// Directed bench for xp_issue_sched (NUM_REQ=4, DW=8, LATENCY=3).
module tb_xp_issue_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_valid_i;
  logic [31:0] req_op1_i, req_op2_i;
  logic [3:0]  req_ready_o;
  logic        flush_i;
  logic        dp_valid_o;
  logic [7:0]  dp_op1_o, dp_op2_o;
  logic [7:0]  dp_res_i, dp_res2_i;
  logic [3:0]  rsp_valid_o;
  logic [7:0]  rsp_res_o, rsp_res2_o;
  logic        busy_o, drain_done_o;

  int checks = 0;
  int errors = 0;

  xp_issue_sched #(.NUM_REQ(4), .DW(8), .LATENCY(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
    .req_ready_o(req_ready_o), .flush_i(flush_i),
    .dp_valid_o(dp_valid_o), .dp_op1_o(dp_op1_o), .dp_op2_o(dp_op2_o),
    .dp_res_i(dp_res_i), .dp_res2_i(dp_res2_i),
    .rsp_valid_o(rsp_valid_o), .rsp_res_o(rsp_res_o), .rsp_res2_o(rsp_res2_o),
    .busy_o(busy_o), .drain_done_o(drain_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0] exp_gnt;
  logic [7:0] exp_op;

  initial begin
    rst_ni = 1'b0; req_valid_i = '0; req_op1_i = '0; req_op2_i = '0;
    flush_i = 1'b0; dp_res_i = '0; dp_res2_i = '0;
    #2;
    chk("rst_dp_valid", 32'(dp_valid_o), 0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_drain_done", 32'(drain_done_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Single op from requester 0
    tick(); req_valid_i = 4'b0001; req_op1_i = 32'h0000_0003; req_op2_i = 32'h0000_0005; #1;
    chk("a_ready", 32'(req_ready_o), 32'h1);
    tick(); req_valid_i = '0; #1;
    chk("a_dp_valid", 32'(dp_valid_o), 1);
    chk("a_dp_op1", 32'(dp_op1_o), 3);
    chk("a_dp_op2", 32'(dp_op2_o), 5);
    chk("a_busy", 32'(busy_o), 1);
    tick(); #1;
    chk("a_dp_valid_low", 32'(dp_valid_o), 0);
    chk("a_dp_op1_hold", 32'(dp_op1_o), 3);
    tick();
    tick(); dp_res_i = 8'h28; dp_res2_i = 8'h77;
    tick(); dp_res_i = '0; dp_res2_i = '0; #1;
    chk("a_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("a_rsp_res", 32'(rsp_res_o), 32'h28);
    chk("a_rsp_res2", 32'(rsp_res2_o), 32'h77);
    tick(); #1;
    chk("a_rsp_valid_low", 32'(rsp_valid_o), 0);
    chk("a_busy_low", 32'(busy_o), 0);

    // Reset clears captured operands; then all four requesters stream
    rst_ni = 1'b0; #1;
    chk("r2_dp_op1", 32'(dp_op1_o), 0);
    chk("r2_dp_op2", 32'(dp_op2_o), 0);
    tick(); rst_ni = 1'b1;
    req_op1_i = 32'h1312_1110; req_op2_i = 32'h2322_2120;
    exp_op = '0;
    for (int k = 0; k < 6; k++) begin
      tick(); req_valid_i = 4'b1111; #1;
`ifdef XP_ISSUE_FIXED_PRIO_EN
      exp_gnt = 4'b0001;
`else
      exp_gnt = 4'(1 << (k % 4));
`endif
      chk("b_grant", 32'(req_ready_o), 32'(exp_gnt));
      if (k > 0) chk("b_dp_op1", 32'(dp_op1_o), 32'(exp_op));
      exp_op = (exp_gnt == 4'b0001) ? 8'h10 : (exp_gnt == 4'b0010) ? 8'h11 :
               (exp_gnt == 4'b0100) ? 8'h12 : 8'h13;
    end
    tick(); req_valid_i = '0; #1;
    chk("b_dp_valid", 32'(dp_valid_o), 1);
    chk("b_dp_op1_last", 32'(dp_op1_o), 32'(exp_op));
    repeat (8) tick();
    chk("b_busy_low", 32'(busy_o), 0);

    // Transfers to 2 then 1, ordered responses
    tick(); req_valid_i = 4'b0100; #1;
    chk("c_ready2", 32'(req_ready_o), 32'h4);
    tick(); req_valid_i = 4'b0010; #1;
    chk("c_ready1", 32'(req_ready_o), 32'h2);
    chk("c_dp_op1", 32'(dp_op1_o), 32'h12);
    tick(); req_valid_i = '0;
    tick();
    tick(); dp_res_i = 8'hA2;
    tick(); dp_res_i = 8'hA1; #1;
    chk("c_rsp2_valid", 32'(rsp_valid_o), 32'h4);
    chk("c_rsp2_res", 32'(rsp_res_o), 32'hA2);
    tick(); dp_res_i = '0; #1;
    chk("c_rsp1_valid", 32'(rsp_valid_o), 32'h2);
    chk("c_rsp1_res", 32'(rsp_res_o), 32'hA1);
    chk("c_busy_t6", 32'(busy_o), 1);
    tick(); #1;
    chk("c_busy_t7", 32'(busy_o), 0);
    chk("c_rsp_low", 32'(rsp_valid_o), 0);

    // Flush after a transfer with requester 3 waiting
    tick(); req_valid_i = 4'b0001; #1;
    chk("d_ready0", 32'(req_ready_o), 32'h1);
    tick(); req_valid_i = 4'b1000; flush_i = 1'b1; #1;
    chk("d_flush_wins", 32'(req_ready_o), 0);
    tick(); flush_i = 1'b0; #1;
    chk("d_drain_ready_t2", 32'(req_ready_o), 0);
    chk("d_done_t2", 32'(drain_done_o), 0);
    tick(); #1;
    chk("d_drain_ready_t3", 32'(req_ready_o), 0);
    tick(); dp_res_i = 8'h55; #1;
    chk("d_drain_ready_t4", 32'(req_ready_o), 0);
    tick(); dp_res_i = '0; #1;
    chk("d_done_t5", 32'(drain_done_o), 1);
    chk("d_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("d_rsp_res", 32'(rsp_res_o), 32'h55);
    chk("d_ready3", 32'(req_ready_o), 32'h8);
    tick(); req_valid_i = '0; #1;
    chk("d_done_pulse", 32'(drain_done_o), 0);
    chk("d_dp_op1", 32'(dp_op1_o), 32'h13);
    repeat (8) tick();
    chk("d_busy_low", 32'(busy_o), 0);

    // Flush from an empty IDLE
    tick(); flush_i = 1'b1;
    tick(); flush_i = 1'b0; req_valid_i = 4'b0001; #1;
    chk("f_drain_ready", 32'(req_ready_o), 0);
    chk("f_done_early", 32'(drain_done_o), 0);
    tick(); #1;
    chk("f_done", 32'(drain_done_o), 1);
    chk("f_ready_idle", 32'(req_ready_o), 32'h1);
    tick(); req_valid_i = '0; #1;
    chk("f_done_pulse", 32'(drain_done_o), 0);
    repeat (8) tick();

    // Reset while an operation is in flight
    tick(); req_valid_i = 4'b0100; #1;
    chk("e_ready2", 32'(req_ready_o), 32'h4);
    tick(); req_valid_i = '0; #1;
    chk("e_busy", 32'(busy_o), 1);
    chk("e_dp_op1", 32'(dp_op1_o), 32'h12);
    tick(); rst_ni = 1'b0; #1;
    chk("e_rst_busy", 32'(busy_o), 0);
    chk("e_rst_dp_op1", 32'(dp_op1_o), 0);
    chk("e_rst_rsp", 32'(rsp_valid_o), 0);
    tick(); rst_ni = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(); dp_res_i = 8'hEE; #1;
      chk("e_no_rsp", 32'(rsp_valid_o), 0);
      chk("e_no_busy", 32'(busy_o), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xp_issue_sched.md
XP_ISSUE_SCHED -- requirements
Module: xp_issue_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the add/multiply/add datapath (2..8).
REQ-002 Parameter DW, default 8, operand/result width.
REQ-003 Parameter LATENCY, default 3, datapath cycles from dp_valid_o sample to dp_res_i valid (1..8).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 req_valid_i  in  NUM_REQ  per-requester operation request.
REQ-007 req_op1_i, req_op2_i  in  NUM_REQ*DW each  packed operands; requester i at bits [i*DW +: DW].
REQ-008 req_ready_o  out  NUM_REQ  one-hot grant, combinational.
REQ-009 flush_i  in  1  stop issue and drain in-flight operations.
REQ-010 dp_valid_o  out  1  operation launched into datapath.
REQ-011 dp_op1_o, dp_op2_o  out  DW each  datapath operands.
REQ-012 dp_res_i, dp_res2_i  in  DW each  datapath results.
REQ-013 rsp_valid_o  out  NUM_REQ  one-hot result return.
REQ-014 rsp_res_o, rsp_res2_o  out  DW each  returned results.
REQ-015 busy_o  out  1  any operation in flight.
REQ-016 drain_done_o  out  1  one-cycle pulse at end of drain.

Function
REQ-017 Transfer on requester i occurs in a cycle where req_valid_i[i] and req_ready_o[i] are both 1; at most one transfer per cycle.
REQ-018 req_ready_o is all-zero in DRAIN state, or when flush_i=1, or when no req_valid_i bit is set.
REQ-019 Round-robin: search starts at pointer P; first valid requester at or after P (mod NUM_REQ) is granted; after a transfer to i, P <= (i+1) mod NUM_REQ; P unchanged without transfer.
REQ-020 Requester asserting req_valid_i holds it and its operands stable until transfer; grant does not depend on req_ready_o history.
REQ-021 Transfer in cycle T -> dp_valid_o=1 with captured operands in cycle T+1; dp_valid_o=0 otherwise, dp_op*_o hold last values.
REQ-022 Requester ID travels in a LATENCY+1-deep tag shift register alongside dp_valid_o.
REQ-023 dp_res_i/dp_res2_i sampled in cycle T+1+LATENCY; rsp_valid_o[ID]=1 with rsp_res_o/rsp_res2_o in cycle T+2+LATENCY for exactly one cycle; no response backpressure.
REQ-024 Back-to-back transfers produce back-to-back responses, order preserved.
REQ-025 In-flight counter 0..LATENCY+1: +1 on transfer, -1 on response; simultaneous both leaves it unchanged; busy_o = counter!=0.
REQ-026 FSM states IDLE, RUN, DRAIN; IDLE->RUN on transfer; RUN->IDLE when counter reaches 0 with no transfer; IDLE/RUN->DRAIN on flush_i=1; DRAIN->IDLE when counter=0, with drain_done_o=1 that cycle.
REQ-027 flush_i in IDLE with counter=0: DRAIN lasts one cycle, drain_done_o pulses next cycle; flush_i in DRAIN ignored.
REQ-028 flush_i and req_valid_i in the same cycle: flush wins, no transfer, P unchanged.
REQ-029 In-flight operations during DRAIN complete and return responses normally.

Reset
REQ-030 rst_ni=0 immediately forces: state IDLE, P=0, counter=0, tag pipeline invalid, dp_valid_o=0, dp_op*_o=0, rsp_valid_o=0, rsp_res*_o=0, busy_o=0, drain_done_o=0.
REQ-031 Reset mid-operation discards all in-flight operations; no response is ever produced for them after reset release.

Configuration
REQ-032 Macro XP_ISSUE_FIXED_PRIO_EN defined: fixed priority, lowest index wins, P unused; undefined: round-robin per REQ-019.

Verification (NUM_REQ=4, LATENCY=3, DW=8)
REQ-033 req 0 valid op1=3 op2=5 at T, dp_res_i=0x28 at T+4 -> dp_valid_o at T+1 with 3/5, rsp_valid_o=0001 with 0x28 at T+5.
REQ-034 All four valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles; with XP_ISSUE_FIXED_PRIO_EN grants 0 every cycle.
REQ-035 Transfers to 2 then 1 at T, T+1 -> rsp_valid_o=0100 at T+5, 0010 at T+6; busy_o falls at T+7.
REQ-036 flush_i at T+1 after transfer at T with req 3 valid -> no grant until IDLE; rsp at T+5; drain_done_o at T+5.
REQ-037 rst_ni low at T+2 after transfer at T -> all outputs 0 immediately; no rsp_valid_o after release.
